// File: rtl/serv_axi_boot_loader.sv
// Boot loader for the SERV core: streams an image into core RAM over single-beat
// AXI writes while holding the core in reset, then releases it after a guard delay.
module serv_axi_boot_loader #(
    parameter int AW            = 13,
    parameter int MEMSIZE       = 8192,
    parameter int RELEASE_DELAY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW-2:0] word_cnt,
    output logic [AW-1:0] m_awaddr,
    output logic          m_awvalid,
    input  logic          m_awready,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_wstrb,
    output logic          m_wvalid,
    input  logic          m_wready,
    input  logic [1:0]    m_bresp,
    input  logic          m_bvalid,
    output logic          m_bready
);

    localparam int WORDS = MEMSIZE / 4;

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, XFER, RESP, RELEASE, RUN, ERROR
    } state_t;

    state_t        r_state;
    logic          r_sReady;
    logic          r_coreRst;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_errCode;
    logic [AW-2:0] r_wordCnt;
    logic [AW-1:0] r_awaddr;
    logic          r_awvalid;
    logic [31:0]   r_wdata;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_last;
    logic [7:0]    r_relCnt;

    logic [AW-2:0] w_cntNext;
    logic [AW:0]   w_addrFull;
    logic          w_awOk;
    logic          w_wOk;

    assign w_cntNext  = r_wordCnt + 1'b1;
    assign w_addrFull = {r_wordCnt, 2'b00};
    // A channel counts as finished once its valid has dropped or its handshake is happening now.
    assign w_awOk     = !r_awvalid || m_awready;
    assign w_wOk      = !r_wvalid || m_wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_sReady  <= 1'b0;
            r_coreRst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= 2'd0;
            r_wordCnt <= '0;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_last    <= 1'b0;
            r_relCnt  <= '0;
        end else begin
            case (r_state)
                IDLE, RUN, ERROR: begin
                    if (start) begin
                        r_state   <= WAIT_DATA;
                        r_coreRst <= 1'b1;
                        r_wordCnt <= '0;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_errCode <= 2'd0;
                        r_busy    <= 1'b1;
                        r_sReady  <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (s_valid && r_sReady) begin
                        r_sReady  <= 1'b0;
                        r_wdata   <= s_data;
                        r_last    <= s_last;
                        r_awaddr  <= w_addrFull[AW-1:0];
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= XFER;
                    end
                end
                XFER: begin
                    if (r_awvalid && m_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_awOk && w_wOk) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_bresp != 2'b00) begin
                            r_state   <= ERROR;
                            r_errCode <= 2'd1;
                            r_err     <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_wordCnt <= w_cntNext;
                            if (r_last) begin
                                r_state  <= RELEASE;
                                r_relCnt <= 8'(RELEASE_DELAY - 1);
                            end else if (32'(w_cntNext) == WORDS) begin
                                r_state   <= ERROR;
                                r_errCode <= 2'd2;
                                r_err     <= 1'b1;
                                r_busy    <= 1'b0;
                            end else begin
                                r_state  <= WAIT_DATA;
                                r_sReady <= 1'b1;
                            end
                        end
                    end
                end
                RELEASE: begin
                    // Counter is preloaded one short so core_rst falls RELEASE_DELAY cycles after the final B.
                    if (r_relCnt == 8'd0) begin
                        r_state   <= RUN;
                        r_coreRst <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_relCnt <= r_relCnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready   = r_sReady;
    assign core_rst  = r_coreRst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_errCode;
    assign word_cnt  = r_wordCnt;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;

endmodule

// File: tb/tb_serv_axi_boot_loader.sv
// Bench for serv_axi_boot_loader: a scoreboarded AXI slave/monitor plus directed load sessions
// on a default instance and on a 16-byte-RAM instance for the overflow case.
`timescale 1ns/1ps
module tb_serv_axi_boot_loader;
    localparam int AW = 13;
    localparam int RD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, sValid, sLast, sel;
    logic [31:0]   sData;
    logic          mAwready, mWready, mBvalid;
    logic [1:0]    mBresp;

    logic          d0SReady, d0CoreRst, d0Busy, d0Done, d0Err, d0Awvalid, d0Wvalid, d0Bready;
    logic [1:0]    d0ErrCode;
    logic [AW-2:0] d0WordCnt;
    logic [AW-1:0] d0Awaddr;
    logic [31:0]   d0Wdata;
    logic [3:0]    d0Wstrb;
    logic          d1SReady, d1CoreRst, d1Busy, d1Done, d1Err, d1Awvalid, d1Wvalid, d1Bready;
    logic [1:0]    d1ErrCode;
    logic [AW-2:0] d1WordCnt;
    logic [AW-1:0] d1Awaddr;
    logic [31:0]   d1Wdata;
    logic [3:0]    d1Wstrb;

    logic          sReady, coreRst, busy, done, err, mAwvalid, mWvalid, mBready;
    logic [1:0]    errCode;
    logic [AW-2:0] wordCnt;
    logic [AW-1:0] mAwaddr;
    logic [31:0]   mWdata;
    logic [3:0]    mWstrb;
    logic          start0, start1;

    assign start0   = start & ~sel;
    assign start1   = start & sel;
    assign sReady   = sel ? d1SReady  : d0SReady;
    assign coreRst  = sel ? d1CoreRst : d0CoreRst;
    assign busy     = sel ? d1Busy    : d0Busy;
    assign done     = sel ? d1Done    : d0Done;
    assign err      = sel ? d1Err     : d0Err;
    assign errCode  = sel ? d1ErrCode : d0ErrCode;
    assign wordCnt  = sel ? d1WordCnt : d0WordCnt;
    assign mAwaddr  = sel ? d1Awaddr  : d0Awaddr;
    assign mAwvalid = sel ? d1Awvalid : d0Awvalid;
    assign mWdata   = sel ? d1Wdata   : d0Wdata;
    assign mWstrb   = sel ? d1Wstrb   : d0Wstrb;
    assign mWvalid  = sel ? d1Wvalid  : d0Wvalid;
    assign mBready  = sel ? d1Bready  : d0Bready;

    serv_axi_boot_loader #(.AW(AW), .MEMSIZE(8192), .RELEASE_DELAY(RD)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .s_valid(sValid), .s_ready(d0SReady),
        .s_data(sData), .s_last(sLast), .core_rst(d0CoreRst), .busy(d0Busy), .done(d0Done),
        .err(d0Err), .err_code(d0ErrCode), .word_cnt(d0WordCnt), .m_awaddr(d0Awaddr),
        .m_awvalid(d0Awvalid), .m_awready(mAwready), .m_wdata(d0Wdata), .m_wstrb(d0Wstrb),
        .m_wvalid(d0Wvalid), .m_wready(mWready), .m_bresp(mBresp), .m_bvalid(mBvalid),
        .m_bready(d0Bready));

    serv_axi_boot_loader #(.AW(AW), .MEMSIZE(16), .RELEASE_DELAY(RD)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_valid(sValid), .s_ready(d1SReady),
        .s_data(sData), .s_last(sLast), .core_rst(d1CoreRst), .busy(d1Busy), .done(d1Done),
        .err(d1Err), .err_code(d1ErrCode), .word_cnt(d1WordCnt), .m_awaddr(d1Awaddr),
        .m_awvalid(d1Awvalid), .m_awready(mAwready), .m_wdata(d1Wdata), .m_wstrb(d1Wstrb),
        .m_wvalid(d1Wvalid), .m_wready(mWready), .m_bresp(mBresp), .m_bvalid(mBvalid),
        .m_bready(d1Bready));

    int checks = 0;
    int fails  = 0;

    logic [AW-1:0] awQ[$];
    logic [31:0]   wQ[$];
    logic [1:0]    bRespQ[$];
    logic          bLastQ[$];

    int awDelay = 0;
    int wDelay  = 0;
    int expWord = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // AXI slave and scoreboard monitor: readies change on the falling edge, and a handshake
    // seen here is the one that completes on the following rising edge.
    initial begin : axiMonitor
        int awWait, wWait, relCnt;
        bit relArmed, prevAwHs, prevWHs, prevAwPend, prevWPend;
        logic [AW-1:0] prevAddr;
        logic [31:0] prevData;
        logic lastFlag;
        logic [1:0] respVal;
        mAwready = 1'b0; mWready = 1'b0; mBvalid = 1'b0; mBresp = 2'b00;
        awWait = 0; wWait = 0; relCnt = 0; relArmed = 0;
        prevAwHs = 0; prevWHs = 0; prevAwPend = 0; prevWPend = 0;
        prevAddr = '0; prevData = '0;
        forever begin
            @(negedge clk);
            if (prevAwHs) checkOutput("awvalid drop after handshake", mAwvalid, 0);
            if (prevWHs)  checkOutput("wvalid drop after handshake", mWvalid, 0);
            if (prevAwPend && !prevAwHs && mAwvalid) checkOutput("awaddr stable", mAwaddr, prevAddr);
            if (prevWPend && !prevWHs && mWvalid)    checkOutput("wdata stable", mWdata, prevData);
            if (relArmed) begin
                relCnt++;
                if (relCnt == RD) checkOutput("core_rst held before release", coreRst, 1);
                if (relCnt == RD + 1) begin
                    checkOutput("core_rst released on time", coreRst, 0);
                    checkOutput("done at release", done, 1);
                    relArmed = 0;
                end
            end

            if (mAwvalid) begin awWait++; mAwready = (awWait > awDelay); end
            else begin awWait = 0; mAwready = 1'b0; end
            if (mWvalid) begin wWait++; mWready = (wWait > wDelay); end
            else begin wWait = 0; mWready = 1'b0; end
            mBvalid = mBready;
            mBresp  = (bRespQ.size() > 0) ? bRespQ[0] : 2'b00;

            prevAwHs = mAwvalid && mAwready;
            prevWHs  = mWvalid && mWready;
            if (prevAwHs) begin
                if (awQ.size() == 0) checkOutput("unexpected AW write", 1, 0);
                else checkOutput("awaddr", mAwaddr, awQ.pop_front());
            end
            if (prevWHs) begin
                checkOutput("wstrb", mWstrb, 4'hF);
                if (wQ.size() == 0) checkOutput("unexpected W write", 1, 0);
                else checkOutput("wdata", mWdata, wQ.pop_front());
            end
            if (mBvalid && mBready) begin
                if (bRespQ.size() == 0) checkOutput("unexpected B response", 1, 0);
                else begin
                    respVal  = bRespQ.pop_front();
                    lastFlag = bLastQ.pop_front();
                    if (lastFlag && respVal == 2'b00) begin relArmed = 1; relCnt = 0; end
                end
            end
            prevAwPend = mAwvalid; prevAddr = mAwaddr;
            prevWPend  = mWvalid;  prevData = mWdata;
        end
    end

    // Offer one word; on acceptance the expected AW/W/B traffic is queued for the monitor.
    task automatic applyStimulus(input logic [31:0] data, input logic last, input logic [1:0] resp,
                                 input int budget, output bit accepted);
        sValid = 1'b1; sData = data; sLast = last; accepted = 0;
        for (int i = 0; i < budget && !accepted; i++) begin
            if (sReady) begin
                accepted = 1;
                awQ.push_back(AW'(expWord * 4));
                wQ.push_back(data);
                bRespQ.push_back(resp);
                bLastQ.push_back(last);
                expWord++;
            end
            @(negedge clk);
        end
        sValid = 1'b0; sLast = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] data, input logic last, input logic [1:0] resp);
        bit acc;
        applyStimulus(data, last, resp, 100, acc);
        checkOutput("word accepted", acc, 1);
    endtask

    task automatic startSession();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expWord = 0;
    endtask

    task automatic waitEnd();
        int n;
        n = 0;
        while (!(done || err) && n < 200) begin @(negedge clk); n++; end
        checkOutput("session finished in time", done || err, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        bit acc;
        rst = 1'b0; start = 1'b0; sValid = 1'b0; sLast = 1'b0; sData = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset core_rst", coreRst, 1);
        checkOutput("reset s_ready", sReady, 0);
        checkOutput("reset busy/done/err", {busy, done, err}, 0);
        checkOutput("reset valids", {mAwvalid, mWvalid, mBready}, 0);
        checkOutput("reset word_cnt", wordCnt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle core_rst", coreRst, 1);

        // Four-word image, zero-wait slave
        startSession();
        checkOutput("session busy", busy, 1);
        sendWord(32'h11111111, 1'b0, 2'b00);
        sendWord(32'h22222222, 1'b0, 2'b00);
        sendWord(32'h33333333, 1'b0, 2'b00);
        sendWord(32'h44444444, 1'b1, 2'b00);
        waitEnd();
        checkOutput("load4 done", done, 1);
        checkOutput("load4 word_cnt", wordCnt, 4);
        checkOutput("load4 busy", busy, 0);
        repeat (2) @(negedge clk);
        checkOutput("run core_rst", coreRst, 0);

        // Restart from RUN
        startSession();
        checkOutput("restart core_rst", coreRst, 1);
        checkOutput("restart done", done, 0);
        checkOutput("restart busy", busy, 1);
        checkOutput("restart word_cnt", wordCnt, 0);

        // Skewed AW/W readiness
        awDelay = 3; wDelay = 0;
        sendWord(32'hA5A5_0001, 1'b0, 2'b00);
        repeat (6) @(negedge clk);
        awDelay = 0; wDelay = 3;
        sendWord(32'h5A5A_0002, 1'b1, 2'b00);
        waitEnd();
        awDelay = 0; wDelay = 0;
        checkOutput("skew done", done, 1);
        checkOutput("skew word_cnt", wordCnt, 2);
        repeat (2) @(negedge clk);

        // Bad BRESP on the second word
        startSession();
        sendWord(32'hDEAD_0000, 1'b0, 2'b00);
        sendWord(32'hDEAD_0001, 1'b0, 2'b10);
        waitEnd();
        checkOutput("bresp err", err, 1);
        checkOutput("bresp err_code", errCode, 1);
        checkOutput("bresp core_rst", coreRst, 1);
        checkOutput("bresp word_cnt", wordCnt, 1);
        checkOutput("bresp busy/done", {busy, done}, 0);
        repeat (3) @(negedge clk);
        checkOutput("err_code held", errCode, 1);

        // Restart from ERROR, single-word image, start pulsed during XFER
        startSession();
        checkOutput("restart clears err", {err, errCode}, 0);
        applyStimulus(32'hCAFE_F00D, 1'b1, 2'b00, 100, acc);
        checkOutput("word accepted", acc, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitEnd();
        checkOutput("single done", done, 1);
        checkOutput("single err", err, 0);
        checkOutput("single word_cnt", wordCnt, 1);
        repeat (2) @(negedge clk);

        // Asynchronous reset with AW outstanding
        startSession();
        sendWord(32'h0BAD_0000, 1'b0, 2'b00);
        awDelay = 5; wDelay = 5;
        sendWord(32'h0BAD_0001, 1'b0, 2'b00);
        checkOutput("awvalid pending before reset", mAwvalid, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset valids", {mAwvalid, mWvalid, mBready, sReady}, 0);
        checkOutput("async reset core_rst", coreRst, 1);
        checkOutput("async reset status", {busy, done, err, errCode}, 0);
        checkOutput("async reset awaddr", mAwaddr, 0);
        checkOutput("async reset wdata", mWdata, 0);
        checkOutput("async reset word_cnt", wordCnt, 0);
        awQ.delete(); wQ.delete(); bRespQ.delete(); bLastQ.delete();
        awDelay = 0; wDelay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post-reset idle core_rst", coreRst, 1);
        checkOutput("post-reset idle outputs", {busy, sReady, mAwvalid, mWvalid}, 0);

        // Overflow on a 4-word RAM
        sel = 1'b1;
        @(negedge clk);
        startSession();
        sendWord(32'h0000_1000, 1'b0, 2'b00);
        sendWord(32'h0000_1001, 1'b0, 2'b00);
        sendWord(32'h0000_1002, 1'b0, 2'b00);
        sendWord(32'h0000_1003, 1'b0, 2'b00);
        applyStimulus(32'h0000_1004, 1'b0, 2'b00, 20, acc);
        checkOutput("overflow word rejected", acc, 0);
        checkOutput("overflow err", err, 1);
        checkOutput("overflow err_code", errCode, 2);
        checkOutput("overflow word_cnt", wordCnt, 4);
        checkOutput("overflow core_rst", coreRst, 1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", awQ.size() + wQ.size() + bRespQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
